// File: rtl/tblink_rpc_pkg.sv
// ============================================================================
// Module  : tblink_rpc_pkg
// Brief   : Shared demux state encoding and TBLink RPC packet field constants.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package tblink_rpc_pkg;

  typedef enum logic [2:0] {
    DMX_DST     = 3'd0,
    DMX_SZ      = 3'd1,
    DMX_BODY    = 3'd2,
    DMX_DROP_SZ = 3'd3,
    DMX_DROP    = 3'd4
  } demux_state_e;

  localparam int         c_CNT_W     = 9;
  localparam logic [7:0] c_CMD_RSP   = 8'h00;
  localparam logic [7:0] c_CTRL_ADDR = 8'h00;

endpackage

`default_nettype wire

// File: rtl/tblink_rpc_pkt_demux_hold.sv
// ============================================================================
// Module  : tblink_rpc_pkt_demux_hold
// Brief   : Single-entry 8-bit output holding register with valid/ready.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tblink_rpc_pkt_demux_hold (
  input  logic       uclock,
  input  logic       reset,
  input  logic       load_i,
  input  logic [7:0] dat_i,
  input  logic       ready_i,
  output logic       valid_o,
  output logic [7:0] dat_o
);

  logic       valid_q;
  logic [7:0] dat_q;

  // A load in the same cycle as a downstream transfer keeps the entry full.
  always_ff @(posedge uclock or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      dat_q   <= 8'h00;
    end else if (load_i) begin
      valid_q <= 1'b1;
      dat_q   <= dat_i;
    end else if (valid_q && ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign dat_o   = dat_q;

endmodule

`default_nettype wire

// File: rtl/tblink_rpc_pkt_demux.sv
// ============================================================================
// Module  : tblink_rpc_pkt_demux
// Brief   : Strips DST and routes SZ+body to one of N_PORTS processors.
//           Optional drop counter: TBLINK_RPC_PKT_DEMUX_DROP_CNT_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tblink_rpc_pkt_demux
  import tblink_rpc_pkg::*;
#(
  parameter int N_PORTS   = 2,
  parameter int ADDR_BASE = 1
) (
  input  logic               uclock,
  input  logic               reset,
  input  logic [7:0]         in_dat,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [7:0]         out_dat,
  output logic [N_PORTS-1:0] out_valid,
  input  logic [N_PORTS-1:0] out_ready,
  output logic               busy
`ifdef TBLINK_RPC_PKT_DEMUX_DROP_CNT_EN
  ,
  output logic [7:0]         drop_count
`endif
);

  localparam int         SEL_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam logic [8:0] c_LO  = 9'(ADDR_BASE);
  localparam logic [8:0] c_HI  = 9'(ADDR_BASE + N_PORTS);

  demux_state_e       state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [c_CNT_W-1:0] cnt_q, cnt_d;

  logic             w_in_fire;
  logic             w_fwd;
  logic             w_hold_valid;
  logic             w_sel_ready;
  logic             w_in_range;
  logic [SEL_W-1:0] w_dst_sel;
`ifdef TBLINK_RPC_PKT_DEMUX_DROP_CNT_EN
  logic             w_pkt_drop;
  logic [7:0]       drop_count_q;
`endif

  assign w_in_range  = ({1'b0, in_dat} >= c_LO) && ({1'b0, in_dat} < c_HI);
  assign w_dst_sel   = SEL_W'({1'b0, in_dat} - c_LO);
  assign w_sel_ready = out_ready[sel_q];
  assign w_in_fire   = in_valid && in_ready;
  assign busy        = (state_q != DMX_DST);

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    cnt_d    = cnt_q;
    in_ready = 1'b1;
    w_fwd    = 1'b0;
`ifdef TBLINK_RPC_PKT_DEMUX_DROP_CNT_EN
    w_pkt_drop = 1'b0;
`endif
    case (state_q)
      DMX_DST: begin
        // Hold off a DST that would retarget sel while the last byte is parked.
        in_ready = !(w_hold_valid && w_in_range && (w_dst_sel != sel_q));
        if (w_in_fire) begin
          if (w_in_range) begin
            sel_d   = w_dst_sel;
            state_d = DMX_SZ;
          end else begin
            state_d = DMX_DROP_SZ;
          end
        end
      end
      DMX_SZ: begin
        in_ready = !w_hold_valid || w_sel_ready;
        if (w_in_fire) begin
          cnt_d   = {1'b0, in_dat} + 9'd1;
          w_fwd   = 1'b1;
          state_d = DMX_BODY;
        end
      end
      DMX_BODY: begin
        in_ready = !w_hold_valid || w_sel_ready;
        if (w_in_fire) begin
          cnt_d = cnt_q - 9'd1;
          w_fwd = 1'b1;
          if (cnt_q == 9'd1) state_d = DMX_DST;
        end
      end
      DMX_DROP_SZ: begin
        if (w_in_fire) begin
          cnt_d   = {1'b0, in_dat} + 9'd1;
          state_d = DMX_DROP;
        end
      end
      DMX_DROP: begin
        if (w_in_fire) begin
          cnt_d = cnt_q - 9'd1;
          if (cnt_q == 9'd1) begin
            state_d = DMX_DST;
`ifdef TBLINK_RPC_PKT_DEMUX_DROP_CNT_EN
            w_pkt_drop = 1'b1;
`endif
          end
        end
      end
      default: state_d = DMX_DST;
    endcase
  end

  always_ff @(posedge uclock or posedge reset) begin
    if (reset) begin
      state_q <= DMX_DST;
      sel_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef TBLINK_RPC_PKT_DEMUX_DROP_CNT_EN
  always_ff @(posedge uclock or posedge reset) begin
    if (reset) begin
      drop_count_q <= 8'h00;
    end else if (w_pkt_drop && (drop_count_q != 8'hFF)) begin
      drop_count_q <= drop_count_q + 8'h01;
    end
  end

  assign drop_count = drop_count_q;
`endif

  tblink_rpc_pkt_demux_hold u_hold (
    .uclock  (uclock),
    .reset   (reset),
    .load_i  (w_fwd),
    .dat_i   (in_dat),
    .ready_i (w_sel_ready),
    .valid_o (w_hold_valid),
    .dat_o   (out_dat)
  );

  for (genvar i = 0; i < N_PORTS; i++) begin : g_out_valid
    assign out_valid[i] = w_hold_valid && (sel_q == SEL_W'(i));
  end

endmodule

`default_nettype wire
